// File: rtl/decodificador_funcionalidade_seq.sv
// Registered function-select decoder: latches a function code, drives a one-hot enable until cancel/disable/timeout.
// Optional build macro SEL_CONFIRM_EN: a valid code commits only after a second matching strobe.
module decodificador_funcionalidade_seq #(
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned N_FUNC  = 7,
    parameter int unsigned TIMEOUT = 0,
    parameter int unsigned TMR_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [SEL_W-1:0]  sel,
    input  logic              sel_valid,
    input  logic              cancel,
    output logic [N_FUNC-1:0] func_onehot,
    output logic [SEL_W-1:0]  func_code,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;

    logic sel_zero;
    logic code_ok;
    logic code_bad;
    logic commit;
    logic expire;

    // Classify the requested code independently of the strobe
    always_comb begin
        sel_zero = (sel == '0);
        code_ok  = !sel_zero && (sel <= SEL_W'(N_FUNC));
        code_bad = !sel_zero && !code_ok;
        expire   = (TIMEOUT != 0) && (timer == TMR_W'(1));
    end

`ifdef SEL_CONFIRM_EN
    logic [SEL_W-1:0] pend_code;
    logic             pend_vld;

    assign commit = code_ok && pend_vld && (pend_code == sel);

    // Pending code waiting for its confirming second strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_code <= '0;
            pend_vld  <= 1'b0;
        end else if (!en || cancel) begin
            pend_code <= '0;
            pend_vld  <= 1'b0;
        end else if (sel_valid) begin
            if (sel_zero) begin
                if (state == ACTIVE) begin
                    pend_code <= '0;
                    pend_vld  <= 1'b0;
                end
            end else if (code_bad || commit) begin
                pend_code <= '0;
                pend_vld  <= 1'b0;
            end else begin
                pend_code <= sel;
                pend_vld  <= 1'b1;
            end
        end
    end
`else
    assign commit = code_ok;
`endif

    // State, timer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            timer       <= '0;
            func_onehot <= '0;
            func_code   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && sel_valid) begin
                        if (commit) begin
                            state       <= ACTIVE;
                            func_onehot <= N_FUNC'(1) << (sel - SEL_W'(1));
                            func_code   <= sel;
                            busy        <= 1'b1;
                            timer       <= TMR_W'(TIMEOUT);
                        end else if (code_bad) begin
                            err <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (!en) begin
                        state       <= IDLE;
                        func_onehot <= '0;
                        func_code   <= '0;
                        busy        <= 1'b0;
                        timer       <= '0;
                    end else if (cancel || (sel_valid && sel_zero)) begin
                        state       <= IDLE;
                        func_onehot <= '0;
                        func_code   <= '0;
                        busy        <= 1'b0;
                        timer       <= '0;
                        done        <= 1'b1;
                    end else if (sel_valid && commit) begin
                        func_onehot <= N_FUNC'(1) << (sel - SEL_W'(1));
                        func_code   <= sel;
                        timer       <= TMR_W'(TIMEOUT);
                    end else begin
                        // Invalid or unconfirmed strobes leave the timer running
                        if (sel_valid && code_bad) begin
                            err <= 1'b1;
                        end
                        if (expire) begin
                            state       <= IDLE;
                            func_onehot <= '0;
                            func_code   <= '0;
                            busy        <= 1'b0;
                            timer       <= '0;
                            done        <= 1'b1;
                        end else if (TIMEOUT != 0) begin
                            timer <= timer - TMR_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decodificador_funcionalidade_seq.sv
// Scoreboard bench for decodificador_funcionalidade_seq across three parameter sets.
module tb_decodificador_funcionalidade_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en   [3];
    logic       sv   [3];
    logic [2:0] sel  [3];
    logic       cn   [3];

    logic [6:0] oh0, oh1;
    logic [4:0] oh2;
    logic [2:0] code0, code1, code2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;
    logic       err0, err1, err2;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         d;
        int         cyc;
        logic [6:0] oh;
        logic [2:0] code;
        logic       busy;
        logic       done;
        logic       err;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    decodificador_funcionalidade_seq #(.SEL_W(3), .N_FUNC(7), .TIMEOUT(0), .TMR_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en[0]), .sel(sel[0]), .sel_valid(sv[0]), .cancel(cn[0]),
        .func_onehot(oh0), .func_code(code0), .busy(busy0), .done(done0), .err(err0));

    decodificador_funcionalidade_seq #(.SEL_W(3), .N_FUNC(7), .TIMEOUT(4), .TMR_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en[1]), .sel(sel[1]), .sel_valid(sv[1]), .cancel(cn[1]),
        .func_onehot(oh1), .func_code(code1), .busy(busy1), .done(done1), .err(err1));

    decodificador_funcionalidade_seq #(.SEL_W(3), .N_FUNC(5), .TIMEOUT(3), .TMR_W(8)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en[2]), .sel(sel[2]), .sel_valid(sv[2]), .cancel(cn[2]),
        .func_onehot(oh2), .func_code(code2), .busy(busy2), .done(done2), .err(err2));

    function automatic logic [12:0] actual(input int d);
        case (d)
            0:       return {oh0, code0, busy0, done0, err0};
            1:       return {oh1, code1, busy1, done1, err1};
            default: return {2'b00, oh2, code2, busy2, done2, err2};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got oh=%b code=%0d busy=%b done=%b err=%b, need oh=%b code=%0d busy=%b done=%b err=%b",
                     nm, act[12:6], act[5:3], act[2], act[1], act[0],
                     req[12:6], req[5:3], req[2], req[1], req[0]);
        end
    endtask

    // Drive one cycle of stimulus to DUT d and queue the outputs expected after the next edge
    task automatic step(input int d, input logic e, input logic v, input logic [2:0] s, input logic c,
                        input logic [2:0] xc, input logic xd, input logic xe);
        exp_t       x;
        logic [6:0] one;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            sv[i] = 1'b0;
            cn[i] = 1'b0;
        end
        en[d]  = e;
        sv[d]  = v;
        sel[d] = s;
        cn[d]  = c;
        one    = 7'd1;
        x.d    = d;
        x.cyc  = cyc + 1;
        x.code = xc;
        x.oh   = (xc == 3'd0) ? 7'd0 : (one << (xc - 3'd1));
        x.busy = (xc != 3'd0);
        x.done = xd;
        x.err  = xe;
        q.push_back(x);
    endtask

    // Monitor: compare every queued expectation once its cycle arrives
    initial begin
        exp_t  x;
        string nm;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                x = q.pop_front();
                if (x.cyc != cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL stale_dut%0d: got cycle %0d, need cycle %0d", x.d, cyc, x.cyc);
                end else begin
                    nm = $sformatf("dut%0d_cyc%0d", x.d, x.cyc);
                    chk(nm, actual(x.d), {x.oh, x.code, x.busy, x.done, x.err});
                end
            end
        end
    end

    initial begin
        int w;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            en[i]  = 1'b0;
            sv[i]  = 1'b0;
            sel[i] = 3'd0;
            cn[i]  = 1'b0;
        end
        #12;
        chk("reset_dut0", actual(0), 13'd0);
        chk("reset_dut1", actual(1), 13'd0);
        chk("reset_dut2", actual(2), 13'd0);
        #2 rst_n = 1'b1;

`ifdef SEL_CONFIRM_EN
        step(0, 1, 0, 3'd0, 0, 3'd0, 0, 0);
        step(0, 1, 1, 3'd2, 0, 3'd0, 0, 0);
        step(0, 1, 1, 3'd3, 0, 3'd0, 0, 0);
        step(0, 1, 1, 3'd3, 0, 3'd3, 0, 0);
        step(0, 1, 0, 3'd0, 0, 3'd3, 0, 0);
        step(0, 1, 0, 3'd0, 1, 3'd0, 1, 0);
        step(0, 1, 1, 3'd2, 0, 3'd0, 0, 0);
        step(0, 1, 0, 3'd0, 1, 3'd0, 0, 0);
        step(0, 1, 1, 3'd2, 0, 3'd0, 0, 0);
        step(0, 1, 0, 3'd0, 0, 3'd0, 0, 0);
        step(0, 1, 1, 3'd2, 0, 3'd2, 0, 0);
        step(0, 1, 1, 3'd5, 0, 3'd2, 0, 0);
        step(0, 1, 1, 3'd5, 0, 3'd5, 0, 0);
        step(0, 1, 1, 3'd0, 0, 3'd0, 1, 0);
        step(0, 1, 0, 3'd0, 0, 3'd0, 0, 0);
`else
        // Basic hold/cancel, en handling and simultaneous events (no timeout)
        step(0, 1, 0, 3'd0, 0, 3'd0, 0, 0);
        step(0, 1, 1, 3'd3, 0, 3'd3, 0, 0);
        repeat (4) step(0, 1, 0, 3'd0, 0, 3'd3, 0, 0);
        step(0, 1, 0, 3'd0, 1, 3'd0, 1, 0);
        step(0, 1, 0, 3'd0, 0, 3'd0, 0, 0);
        step(0, 1, 1, 3'd0, 0, 3'd0, 0, 0);
        step(0, 1, 1, 3'd1, 0, 3'd1, 0, 0);
        step(0, 0, 0, 3'd0, 0, 3'd0, 0, 0);
        step(0, 0, 1, 3'd2, 0, 3'd0, 0, 0);
        step(0, 1, 1, 3'd4, 0, 3'd4, 0, 0);
        step(0, 1, 1, 3'd2, 1, 3'd0, 1, 0);
        step(0, 1, 1, 3'd4, 0, 3'd4, 0, 0);
        step(0, 1, 1, 3'd6, 0, 3'd6, 0, 0);
        step(0, 1, 1, 3'd0, 0, 3'd0, 1, 0);
        step(0, 1, 0, 3'd0, 1, 3'd0, 0, 0);
        step(0, 1, 1, 3'd2, 0, 3'd2, 0, 0);
        step(0, 1, 1, 3'd3, 0, 3'd3, 0, 0);
        step(0, 1, 1, 3'd5, 0, 3'd5, 0, 0);
        // Asynchronous reset while active clears outputs immediately
        @(posedge clk);
        #1 sv[0] = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_dut0", actual(0), 13'd0);
        #1 rst_n = 1'b1;
        step(0, 1, 0, 3'd0, 0, 3'd0, 0, 0);

        // Timeout of 4: plain expiry, then reload on the 3rd active cycle
        step(1, 1, 1, 3'd7, 0, 3'd7, 0, 0);
        repeat (3) step(1, 1, 0, 3'd0, 0, 3'd7, 0, 0);
        step(1, 1, 0, 3'd0, 0, 3'd0, 1, 0);
        step(1, 1, 0, 3'd0, 0, 3'd0, 0, 0);
        step(1, 1, 1, 3'd7, 0, 3'd7, 0, 0);
        repeat (2) step(1, 1, 0, 3'd0, 0, 3'd7, 0, 0);
        step(1, 1, 1, 3'd7, 0, 3'd7, 0, 0);
        repeat (3) step(1, 1, 0, 3'd0, 0, 3'd7, 0, 0);
        step(1, 1, 0, 3'd0, 0, 3'd0, 1, 0);
        // Switch on the expiry cycle wins over done
        step(1, 1, 1, 3'd4, 0, 3'd4, 0, 0);
        repeat (3) step(1, 1, 0, 3'd0, 0, 3'd4, 0, 0);
        step(1, 1, 1, 3'd5, 0, 3'd5, 0, 0);
        repeat (3) step(1, 1, 0, 3'd0, 0, 3'd5, 0, 0);
        step(1, 1, 0, 3'd0, 0, 3'd0, 1, 0);

        // N_FUNC=5, timeout 3: invalid codes, and invalid strobe on expiry
        step(2, 1, 1, 3'd6, 0, 3'd0, 0, 1);
        step(2, 1, 0, 3'd0, 0, 3'd0, 0, 0);
        step(2, 1, 1, 3'd7, 0, 3'd0, 0, 1);
        step(2, 0, 1, 3'd6, 0, 3'd0, 0, 0);
        step(2, 1, 1, 3'd2, 0, 3'd2, 0, 0);
        step(2, 1, 1, 3'd6, 0, 3'd2, 0, 1);
        step(2, 1, 0, 3'd0, 0, 3'd2, 0, 0);
        step(2, 1, 1, 3'd6, 0, 3'd0, 1, 1);
        step(2, 1, 0, 3'd0, 0, 3'd0, 0, 0);
`endif

        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            sv[i] = 1'b0;
            cn[i] = 1'b0;
        end
        w = 0;
        while (q.size() > 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        #1;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expectations, need 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
